// File: rtl/display_pkg.sv
// Shared framebuffer geometry, derived widths, frame constants and the
// readback FSM state type.
package display_pkg;

  localparam int unsigned PIXEL_WIDTH     = 64;
  localparam int unsigned PIXEL_HEIGHT    = 32;
  localparam int unsigned BYTES_PER_PIXEL = 2;
  localparam int unsigned TICKS_PER_BIT   = 9;

  // Row index, row count (0..PIXEL_HEIGHT), byte-within-row and RAM address widths
  localparam int unsigned ROW_W  = $clog2(PIXEL_HEIGHT);
  localparam int unsigned CNT_W  = ROW_W + 1;
  localparam int unsigned ROWB_W = $clog2(PIXEL_WIDTH * BYTES_PER_PIXEL);
  localparam int unsigned ADDR_W = ROW_W + ROWB_W;
  // Payload byte index; one bit wider than the address so a full frame fits
  localparam int unsigned IDX_W  = ADDR_W + 1;

  localparam logic [7:0] HEADER_BYTE = 8'h52;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_ARG_ROW,
    ST_ARG_CNT,
    ST_PAYLOAD,
    ST_SUM,
    ST_DRAIN
  } fsm_state_t;

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 LSB-first UART byte serialiser.
// Ports: clk_in/reset (async active-high); data/load hand over a byte when
// ready is high; ready is also high in the final cycle of the stop bit so a
// new byte can follow with no gap; tx is the registered serial line (idle 1).
module uart_tx_byte
  import display_pkg::*;
#(
  parameter int unsigned TICKS = TICKS_PER_BIT
) (
  input  logic       clk_in,
  input  logic       reset,
  input  logic [7:0] data,
  input  logic       load,
  output logic       ready,
  output logic       tx
);

  localparam int unsigned TICK_W   = (TICKS > 1) ? $clog2(TICKS) : 1;
  localparam logic [3:0]  STOP_BIT = 4'd9;
  localparam logic [3:0]  LAST_DAT = 4'd8;

  logic              r_active;
  logic [TICK_W-1:0] r_tick;
  logic [3:0]        r_bit;
  logic [7:0]        r_shift;
  logic              r_tx;

  logic w_bit_end;
  logic w_last;

  assign w_bit_end = (r_tick == TICK_W'(TICKS - 1));
  assign w_last    = r_active && w_bit_end && (r_bit == STOP_BIT);
  assign ready     = !r_active || w_last;
  assign tx        = r_tx;

  // Bit 0 is the start bit, 1..8 data LSB first, 9 the stop bit
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      r_active <= 1'b0;
      r_tick   <= '0;
      r_bit    <= '0;
      r_shift  <= '0;
      r_tx     <= 1'b1;
    end else if (load && ready) begin
      r_active <= 1'b1;
      r_tick   <= '0;
      r_bit    <= '0;
      r_shift  <= data;
      r_tx     <= 1'b0;
    end else if (r_active) begin
      if (w_bit_end) begin
        r_tick <= '0;
        if (r_bit == STOP_BIT) begin
          r_active <= 1'b0;
          r_tx     <= 1'b1;
        end else begin
          r_bit <= r_bit + 4'd1;
          if (r_bit == LAST_DAT) begin
            r_tx <= 1'b1;
          end else begin
            r_tx    <= r_shift[0];
            r_shift <= {1'b0, r_shift[7:1]};
          end
        end
      end else begin
        r_tick <= r_tick + TICK_W'(1);
      end
    end
  end

endmodule

// File: rtl/fb_readback_tx.sv
// Framebuffer readback transmitter: on start, frames a window of rows as
// header, row_start, row_count, payload and XOR checksum, sent 8N1 back-to-back.
// Ports: clk_in/reset (async active-high); start/row_start/row_count request;
// ram_address/ram_clk_enable/ram_data_in read port A (data one cycle after
// the strobe); tx_out serial line; busy for the whole frame; done one-cycle
// pulse after the final stop bit.
module fb_readback_tx
  import display_pkg::*;
(
  input  logic              clk_in,
  input  logic              reset,
  input  logic              start,
  input  logic [ROW_W-1:0]  row_start,
  input  logic [CNT_W-1:0]  row_count,
  output logic [ADDR_W-1:0] ram_address,
  output logic              ram_clk_enable,
  input  logic [7:0]        ram_data_in,
  output logic              tx_out,
  output logic              busy,
  output logic              done
);

  fsm_state_t r_state;
  fsm_state_t w_next;

  logic              r_busy;
  logic              r_done;
  logic              r_ren;
  logic              r_rd_pend;
  logic [ADDR_W-1:0] r_ram_address;
  logic [ROW_W-1:0]  r_row;
  logic [CNT_W-1:0]  r_cnt;
  logic [IDX_W-1:0]  r_fidx;
  logic [IDX_W-1:0]  r_sidx;
  logic [7:0]        r_sum;
  logic [7:0]        r_hold;
  logic              r_hold_v;

  logic              w_load;
  logic [7:0]        w_data;
  logic              w_ready;
  logic              w_accept;
  logic              w_fetch;
  logic              w_consume;
  logic              w_drain_end;
  logic              w_last_byte;
  logic [IDX_W-1:0]  w_total;
  logic [ROW_W-1:0]  w_row;
  logic [ADDR_W-1:0] w_addr;
  logic [CNT_W-1:0]  w_cnt_sat;

  assign ram_address    = r_ram_address;
  assign ram_clk_enable = r_ren;
  assign busy           = r_busy;
  assign done           = r_done;

  // Payload byte count is row_count rows of one power-of-two row each
  assign w_total     = {r_cnt, {ROWB_W{1'b0}}};
  assign w_last_byte = (r_sidx == w_total - IDX_W'(1));
  // Row wraps naturally in the ROW_W-bit add
  assign w_row       = r_row + r_fidx[ADDR_W-1:ROWB_W];
  assign w_addr      = {w_row, r_fidx[ROWB_W-1:0]};
  assign w_cnt_sat   = (row_count > CNT_W'(PIXEL_HEIGHT)) ? CNT_W'(PIXEL_HEIGHT) : row_count;

  assign w_accept    = (r_state == ST_IDLE) && start;
  assign w_consume   = (r_state == ST_PAYLOAD) && w_load;
  assign w_drain_end = (r_state == ST_DRAIN) && w_ready && r_busy;
  // One read in flight at most, only while the holding register is empty
  assign w_fetch     = (r_state inside {ST_HDR, ST_ARG_ROW, ST_ARG_CNT, ST_PAYLOAD})
                       && !r_hold_v && !r_ren && !r_rd_pend && (r_fidx < w_total);

  // State register
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // Next state and byte hand-off to the serialiser
  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    w_data = 8'h00;
    case (r_state)
      ST_IDLE: begin
        if (start) w_next = ST_HDR;
      end
      ST_HDR: begin
        if (w_ready) begin
          w_load = 1'b1;
          w_data = HEADER_BYTE;
          w_next = ST_ARG_ROW;
        end
      end
      ST_ARG_ROW: begin
        if (w_ready) begin
          w_load = 1'b1;
          w_data = 8'(r_row);
          w_next = ST_ARG_CNT;
        end
      end
      ST_ARG_CNT: begin
        if (w_ready) begin
          w_load = 1'b1;
          w_data = 8'(r_cnt);
          w_next = (r_cnt != '0) ? ST_PAYLOAD : ST_SUM;
        end
      end
      ST_PAYLOAD: begin
        if (w_ready && r_hold_v) begin
          w_load = 1'b1;
          w_data = r_hold;
          if (w_last_byte) w_next = ST_SUM;
        end
      end
      ST_SUM: begin
        if (w_ready) begin
          w_load = 1'b1;
          w_data = r_sum;
          w_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // done is high for exactly this one extra DRAIN cycle
        if (r_done) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Request latch, prefetch, checksum and status registers
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_ren         <= 1'b0;
      r_rd_pend     <= 1'b0;
      r_ram_address <= '0;
      r_row         <= '0;
      r_cnt         <= '0;
      r_fidx        <= '0;
      r_sidx        <= '0;
      r_sum         <= '0;
      r_hold        <= '0;
      r_hold_v      <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      r_ren     <= w_fetch;
      r_rd_pend <= r_ren;
      if (w_accept) begin
        r_busy   <= 1'b1;
        r_row    <= row_start;
        r_cnt    <= w_cnt_sat;
        r_fidx   <= '0;
        r_sidx   <= '0;
        r_sum    <= '0;
        r_hold_v <= 1'b0;
      end
      if (w_drain_end) begin
        r_busy <= 1'b0;
        r_done <= 1'b1;
      end
      if (w_fetch) begin
        r_ram_address <= w_addr;
        r_fidx        <= r_fidx + IDX_W'(1);
      end
      if (r_rd_pend) begin
        r_hold   <= ram_data_in;
        r_hold_v <= 1'b1;
      end
      if (w_consume) begin
        r_hold_v <= 1'b0;
        r_sum    <= r_sum ^ r_hold;
        r_sidx   <= r_sidx + IDX_W'(1);
      end
    end
  end

  uart_tx_byte #(
    .TICKS (TICKS_PER_BIT)
  ) u_uart (
    .clk_in (clk_in),
    .reset  (reset),
    .data   (w_data),
    .load   (w_load),
    .ready  (w_ready),
    .tx     (tx_out)
  );

endmodule

// File: tb/tb_fb_readback_tx.sv
// Bench for fb_readback_tx: a frame-level model predicts every output cycle
// from the request, RAM contents and UART timing.
module tb_fb_readback_tx;

  localparam int T         = 9;
  localparam int BYTE_CYC  = 10 * T;
  localparam int ROW_BYTES = 128;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [4:0]  row_start = '0;
  logic [5:0]  row_count = '0;
  logic [11:0] ram_address;
  logic        ram_clk_enable;
  logic [7:0]  ram_rdata = '0;
  logic        tx_out;
  logic        busy;
  logic        done;

  always #5 clk = ~clk;

  fb_readback_tx dut (
    .clk_in         (clk),
    .reset          (rst),
    .start          (start),
    .row_start      (row_start),
    .row_count      (row_count),
    .ram_address    (ram_address),
    .ram_clk_enable (ram_clk_enable),
    .ram_data_in    (ram_rdata),
    .tx_out         (tx_out),
    .busy           (busy),
    .done           (done)
  );

  logic [7:0] mem [4096];
  always @(posedge clk) if (ram_clk_enable) ram_rdata <= mem[ram_address];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame model: built when a request is accepted
  bit         m_valid = 1'b0;
  int         m_n, m_f, m_end;
  int         cyc = 0;
  logic [7:0] m_bytes [4100];
  int         m_addr_arr [4096];
  int         addr_q [$];

  always @(posedge clk or posedge rst) begin
    int cs, a, idx;
    logic [7:0] x;
    if (rst) begin
      m_valid = 1'b0;
      addr_q.delete();
    end else begin
      cyc++;
      if (start && (!m_valid || cyc >= m_end + 2)) begin
        cs = (int'(row_count) > 32) ? 32 : int'(row_count);
        m_valid = 1'b1;
        m_n = cyc;
        m_f = 4 + cs * ROW_BYTES;
        m_end = m_n + 1 + m_f * BYTE_CYC;
        m_bytes[0] = 8'h52;
        m_bytes[1] = 8'(row_start);
        m_bytes[2] = 8'(cs);
        x = 8'h00;
        addr_q.delete();
        for (int r = 0; r < cs; r++) begin
          for (int j = 0; j < ROW_BYTES; j++) begin
            idx = r * ROW_BYTES + j;
            a = ((int'(row_start) + r) % 32) * ROW_BYTES + j;
            m_addr_arr[idx] = a;
            addr_q.push_back(a);
            m_bytes[3 + idx] = mem[12'(a)];
            x = x ^ mem[12'(a)];
          end
        end
        m_bytes[m_f - 1] = x;
      end
    end
  end

  // Every-cycle compare against the model
  always @(negedge clk) begin
    int k, b, bt;
    logic eb, ed, et;
    if (rst) begin
      chk("rst_tx_out", 32'(tx_out), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_ram_en", 32'(ram_clk_enable), 32'd0);
    end else begin
      eb = 1'b0; ed = 1'b0; et = 1'b1;
      if (m_valid) begin
        k  = cyc - (m_n + 1);
        eb = (cyc >= m_n) && (cyc <= m_n + m_f * BYTE_CYC);
        ed = (cyc == m_end);
        if (k >= 0 && k < m_f * BYTE_CYC) begin
          b  = k / BYTE_CYC;
          bt = (k % BYTE_CYC) / T;
          if (bt == 0)      et = 1'b0;
          else if (bt == 9) et = 1'b1;
          else              et = m_bytes[b][bt - 1];
        end
      end
      chk("tx_out", 32'(tx_out), 32'(et));
      chk("busy", 32'(busy), 32'(eb));
      chk("done", 32'(done), 32'(ed));
      if (ram_clk_enable) begin
        if (addr_q.size() == 0) chk("ram_extra_read", 32'(ram_clk_enable), 32'd0);
        else                    chk("ram_address", 32'(ram_address), 32'(addr_q.pop_front()));
      end
    end
  end

  task automatic start_pulse(input int rs, input int rc);
    @(negedge clk);
    row_start = 5'(rs);
    row_count = 6'(rc);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Runs one frame; optionally re-pulses start while busy and in the done cycle
  task automatic run_frame(input int rs, input int rc, input bit pulse,
                           output int bcnt, output int dcnt);
    start_pulse(rs, rc);
    bcnt = 0;
    dcnt = 0;
    for (int i = 0; i < 30000; i++) begin
      if (busy) bcnt++;
      if (done) begin
        dcnt++;
        if (pulse) start = 1'b1;
        break;
      end
      if (pulse && (i % 37 == 5)) begin
        start = 1'b1;
        row_start = 5'($urandom);
        row_count = 6'($urandom_range(0, 2));
      end
      @(negedge clk);
      start = 1'b0;
    end
    chk("frame_done_seen", 32'(dcnt), 32'd1);
    repeat (6) begin
      @(negedge clk);
      start = 1'b0;
      if (done) dcnt++;
    end
    chk("done_once", 32'(dcnt), 32'd1);
    chk("reads_left", 32'(addr_q.size()), 32'd0);
  endtask

  initial begin
    int bc, dc, rs, rc, d;
    bit found;
    for (int i = 0; i < 4096; i++) mem[i] = 8'(i);
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_tx_out", 32'(tx_out), 32'd1);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_ram_en", 32'(ram_clk_enable), 32'd0);
    chk("reset_ram_addr", 32'(ram_address), 32'd0);
    d = 0;
    repeat (100) begin
      @(negedge clk);
      if (done) d++;
    end
    chk("idle_no_done", 32'(d), 32'd0);

    // One row from row 0, RAM holds addr[7:0]
    run_frame(0, 1, 1'b0, bc, dc);
    chk("pin_hdr", 32'(m_bytes[0]), 32'h52);
    chk("pin_arg_row", 32'(m_bytes[1]), 32'h00);
    chk("pin_arg_cnt", 32'(m_bytes[2]), 32'h01);
    chk("pin_pay_first", 32'(m_bytes[3]), 32'h00);
    chk("pin_pay_last", 32'(m_bytes[130]), 32'h7F);
    chk("pin_sum", 32'(m_bytes[131]), 32'h00);
    chk("busy_len_1row", 32'(bc), 32'(132 * 90 + 1));

    // Row wrap 31 -> 0
    run_frame(31, 2, 1'b0, bc, dc);
    chk("pin_wrap_a0", 32'(m_addr_arr[0]), 32'd3968);
    chk("pin_wrap_a127", 32'(m_addr_arr[127]), 32'd4095);
    chk("pin_wrap_a128", 32'(m_addr_arr[128]), 32'd0);
    chk("pin_wrap_a255", 32'(m_addr_arr[255]), 32'd127);
    chk("pin_wrap_row", 32'(m_bytes[1]), 32'h1F);
    chk("pin_wrap_b3", 32'(m_bytes[3]), 32'h80);
    chk("pin_wrap_sum", 32'(m_bytes[259]), 32'h00);
    chk("busy_len_wrap", 32'(bc), 32'(260 * 90 + 1));

    // Empty window with start re-pulsed while busy and in the done cycle
    rs = $urandom_range(0, 31);
    run_frame(rs, 0, 1'b1, bc, dc);
    chk("pin_empty_row", 32'(m_bytes[1]), 32'(rs));
    chk("pin_empty_cnt", 32'(m_bytes[2]), 32'h00);
    chk("pin_empty_sum", 32'(m_bytes[3]), 32'h00);
    chk("busy_len_empty", 32'(bc), 32'(4 * 90 + 1));
    chk("no_queued_start", 32'(busy), 32'd0);

    // Random RAM contents and windows
    for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
    for (int f = 0; f < 2; f++) begin
      rs = $urandom_range(0, 31);
      rc = $urandom_range(0, 1);
      run_frame(rs, rc, 1'b0, bc, dc);
      chk("busy_len_rand", 32'(bc), 32'((4 + rc * 128) * 90 + 1));
    end

    // Oversized count is saturated; reset lands in the payload
    start_pulse($urandom_range(0, 31), $urandom_range(33, 63));
    chk("pin_sat_cnt", 32'(m_bytes[2]), 32'h20);
    repeat (13 * 90) @(negedge clk);
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (tx_out == 1'b0) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("saw_low_bit", 32'(found), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_tx", 32'(tx_out), 32'd1);
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_ram_en", 32'(ram_clk_enable), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    run_frame($urandom_range(0, 31), 1, 1'b0, bc, dc);
    chk("post_rst_hdr", 32'(m_bytes[0]), 32'h52);
    chk("busy_len_post_rst", 32'(bc), 32'(132 * 90 + 1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fb_readback_tx.md
Name: fb_readback_tx

Overview:
- Streams framebuffer contents back to the host over a UART line. It is the transmit-direction counterpart to the control-path receiver.
- Sits beside control_module on the spare framebuffer port-A read path, clocked by clk_root.
- On a start pulse it reads a window of rows from multimem byte-by-byte and frames them as header, args, payload and XOR checksum.
- Serialises the frame 8N1, LSB first, with no inter-byte gaps.

Parameters:
- PIXEL_WIDTH, 64, pixels per row.
- PIXEL_HEIGHT, 32, rows in framebuffer.
- BYTES_PER_PIXEL, 2, bytes per pixel in RAM.
- TICKS_PER_BIT, 9, clk_in cycles per UART bit (from CTRLR_CLK_TICKS_PER_BIT).
- HEADER_BYTE, 8'h52, first byte of every frame.

Ports:
- clk_in  input  1  system clock (clk_root).
- reset  input  1  asynchronous active-high reset.
- start  input  1  one-cycle request; sampled only in IDLE.
- row_start  input  5 ($clog2(PIXEL_HEIGHT))  first row; latched on accepted start.
- row_count  input  6 ($clog2(PIXEL_HEIGHT)+1)  rows to send, 0..PIXEL_HEIGHT; latched on accepted start.
- ram_address  output  12 ($clog2(W*H*BPP))  byte address to framebuffer port A.
- ram_clk_enable  output  1  read strobe; data valid on ram_data_in the following cycle.
- ram_data_in  input  8  framebuffer read data.
- tx_out  output  1  UART serial out; idle high.
- busy  output  1  high from accept until the last stop bit completes.
- done  output  1  one-cycle pulse in the cycle after the final stop bit.

Behaviour:
- Reset values:
  - tx_out=1, busy=0, done=0, ram_clk_enable=0, ram_address=0.
  - FSM=IDLE; all counters and the checksum register = 0.
- Reset asserted mid-frame: abort immediately; tx_out returns high asynchronously. No partial byte is completed.
- Frame byte order:
  - HEADER_BYTE
  - {3'b0,row_start}
  - {2'b0,row_count}
  - payload: for r in 0..row_count-1, row=(row_start+r) mod PIXEL_HEIGHT; for col 0..W-1, byte 0..BPP-1
  - checksum: XOR of payload bytes only (8'h00 if row_count=0)
- Payload address: (row*PIXEL_WIDTH+col)*BYTES_PER_PIXEL+byte. Computed with shifts/concatenation (W, BPP powers of 2), so row wrap comes from the 5-bit row add.
- row_count>PIXEL_HEIGHT is saturated to PIXEL_HEIGHT at latch; the echoed arg byte carries the saturated value.
- FSM states and transitions:
  - IDLE->HDR on start.
  - HDR->ARG_ROW->ARG_CNT->(PAYLOAD if count!=0 else SUM).
  - PAYLOAD->SUM after the last byte is handed to the serialiser.
  - SUM->DRAIN; DRAIN waits for the serialiser to go idle, then done pulses and the FSM returns to IDLE.
- Timing:
  - start high at edge N: busy=1 from N+1; header start bit (tx_out=0) begins at N+2.
  - Each bit lasts exactly TICKS_PER_BIT cycles.
  - Bytes are back-to-back: the next start bit begins the cycle after the previous stop bit ends.
- Prefetch: the next payload byte is read (ram_clk_enable one cycle, data captured the next cycle) into a one-byte holding register while the current byte shifts. The serialiser must never wait on RAM.
- Total busy time = (3 + row_count*W*BPP + 1)*10*TICKS_PER_BIT + 1 cycles.
- start while busy: ignored, no queuing.
- start in the same cycle done pulses: ignored (FSM not yet in IDLE).
- ram_clk_enable is low whenever no read is in flight.

Decomposition:
- Shared package (display_pkg): PIXEL_WIDTH/HEIGHT/BPP-derived widths, HEADER_BYTE constant, and the FSM state enum typedef.
- One sub-module, uart_tx_byte:
  - Ports: clk_in, reset, data[7:0], load, ready, tx.
  - 8N1 LSB-first serialiser with a TICKS_PER_BIT baud counter and bit counter.
  - ready is high in the final cycle of the stop bit, so back-to-back loads are accepted.

Test Plan:
- Reset, then idle 100 cycles -> tx_out=1, busy=0, ram_clk_enable=0, no done.
- Fill RAM with addr[7:0]; start, row_start=0, row_count=1 -> decoded bytes 52,00,01,00..7F, then XOR checksum 8'h00. busy lasts 132*10*9+1 cycles; done pulses once.
- row_start=31, row_count=2 -> payload addresses cover row 31 (3968..4095) then row 0 (0..127), with no stall between rows.
- row_count=0 -> bytes 52,<row>,00,00; busy lasts 4*90+1 cycles.
- start re-pulsed mid-frame and in the done cycle -> ignored; byte stream unchanged.
- reset asserted mid-payload bit -> tx_out=1 immediately, busy=0. A new start afterwards produces a clean frame from HEADER_BYTE.
